// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding,
// tag byte layout and the default start-handshake timeout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TAG_START  = 3'd1,
        TAG_WAIT   = 3'd2,
        DATA_START = 3'd3,
        DATA_WAIT  = 3'd4
    } arb_state_e;

    localparam logic [3:0] TAG_NIBBLE            = 4'hA;
    localparam int         DEFAULT_START_TIMEOUT = 4096;

    function automatic logic [7:0] tag_byte(input logic [1:0] id);
        return {TAG_NIBBLE, 2'b00, id};
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer into the clk domain; flops clear to 0
// on synchronous reset. Used for tx_busy and reusable for switch inputs.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_8n1 among up to four requesters.
// Define UART_ARB_TAG_EN to prefix every payload with a {4'hA,2'b00,id} tag byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [1:0]         grant_id,
    output logic               active,
    output logic               err_timeout
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    arb_state_e       state_q;
    logic [1:0]       last_grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic [1:0]       grant_q;
    logic             active_q;
    logic             err_q;
    logic [7:0]       payload_q;
    logic             busy_s;

    logic             win_vld_d;
    logic [1:0]       win_idx_d;
    logic [7:0]       win_data_d;
    logic [N_REQ-1:0] win_onehot_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_busy_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tx_busy),
        .q_o (busy_s)
    );

    // Priority rotates: the search starts one past the last winner.
    always_comb begin
        win_vld_d    = 1'b0;
        win_idx_d    = '0;
        win_data_d   = '0;
        win_onehot_d = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_vld_d && req[i] && (i == (int'(last_grant_q) + k) % N_REQ)) begin
                    win_vld_d       = 1'b1;
                    win_idx_d       = 2'(i);
                    win_data_d      = req_data[8*i +: 8];
                    win_onehot_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && win_vld_d) begin
            payload_q <= win_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 2'(N_REQ - 1);
            cnt_q        <= '0;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            grant_q      <= 2'd0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        ack_q        <= win_onehot_d;
                        grant_q      <= win_idx_d;
                        last_grant_q <= win_idx_d;
                        cnt_q        <= '0;
                        tx_start_q   <= 1'b1;
                        active_q     <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        tx_data_q    <= tag_byte(win_idx_d);
                        state_q      <= TAG_START;
`else
                        tx_data_q    <= win_data_d;
                        state_q      <= DATA_START;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_START: begin
                    if (busy_s) begin
                        tx_start_q <= 1'b0;
                        state_q    <= TAG_WAIT;
                    end else if (cnt_q == CNT_LAST) begin
                        tx_start_q <= 1'b0;
                        err_q      <= 1'b1;
                        active_q   <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TAG_WAIT: begin
                    if (!busy_s) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= payload_q;
                        cnt_q      <= '0;
                        state_q    <= DATA_START;
                    end
                end
`endif
                DATA_START: begin
                    if (busy_s) begin
                        tx_start_q <= 1'b0;
                        state_q    <= DATA_WAIT;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: the latched byte is dropped, not retried.
                        tx_start_q <= 1'b0;
                        err_q      <= 1'b1;
                        active_q   <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA_WAIT: begin
                    if (!busy_s) begin
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    active_q   <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single `uart_tx_8n1` transmitter among up to four byte-producing requesters, such as the switch-state reporter and counter reporters. It accepts one byte per grant, drives the transmitter's enable/data/busy handshake across the baud-clock domain boundary, and returns a one-cycle acknowledge to the winning requester. It sits between the application reporters and the `uart_tx_8n1` / `baud_clk_generator` pair in the top level.

## Interface
- `N_REQ`, 4: number of requesters, 2..4.
- `SYNC_STAGES`, 2: flop stages on `tx_busy` into the `clk` domain.
- `START_TIMEOUT`, 4096: `clk` cycles to wait for synced busy to rise after `tx_start` before aborting.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester send request; level, held until `ack`.
- `req_data`  in  8*N_REQ  payload bytes; requester i at bits [8i+7:8i]; must be stable while `req[i]` is high.
- `ack`  out  N_REQ  one-cycle pulse; payload of that requester has been latched.
- `tx_start`  out  1  to `uart_tx_8n1` send enable.
- `tx_data`  out  8  to `uart_tx_8n1` data; stable while `tx_start` is high and while busy.
- `tx_busy`  in  1  from `uart_tx_8n1`; asynchronous to `clk` (baud domain).
- `grant_id`  out  2  index of the current or last granted requester.
- `active`  out  1  high whenever the FSM is not IDLE.
- `err_timeout`  out  1  one-cycle pulse on start-handshake abort.

## Operation
- FSM states: IDLE, TAG_START, TAG_WAIT, DATA_START, DATA_WAIT.
- **IDLE, arbitration:**
  - Search starts at `last_grant+1` mod N_REQ.
  - The first requester with `req` high wins.
  - Winner: latch its byte, pulse `ack[i]`, update `grant_id` and `last_grant`.
  - Next state is TAG_START if tagging is compiled in, else DATA_START.
- **\*_START:** `tx_start`=1 with the byte on `tx_data`.
  - When synced busy reads 1: drop `tx_start` and go to \*_WAIT.
  - If the cycle counter reaches `START_TIMEOUT`: drop `tx_start`, pulse `err_timeout`, go to IDLE. The latched byte is discarded and not re-sent.
- **\*_WAIT:** wait for synced busy to read 0.
  - TAG_WAIT goes to DATA_START.
  - DATA_WAIT goes to IDLE.
- Requests arriving while the FSM is not IDLE are only evaluated in the next IDLE cycle.
- Requester signals `req[i]` with i >= N_REQ are ignored.
- `tx_data` holds the last sent byte in IDLE.

## Timing
- **Reset values:**
  - `ack`=0, `tx_start`=0, `tx_data`=0x00, `grant_id`=0, `active`=0, `err_timeout`=0.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
  - Sync flops clear to 0; FSM goes to IDLE; timeout counter clears to 0.
- **Latency:** `req` seen in IDLE at cycle n gives `ack` and the state change at n+1; `tx_start` is high from cycle n+1.
- **Busy detection:** a rising `tx_busy` is seen SYNC_STAGES to SYNC_STAGES+1 cycles later; `tx_start` falls the cycle after that.
- **Minimum spacing:** two grants are separated by at least 1 IDLE cycle.
- **Simultaneous requests:** exactly one `ack` per grant, strictly round-robin.
  - Example: `req`=4'b1111 after reset grants 0,1,2,3,0…
- **Timeout counter:** clears on every \*_START entry and saturates; with N = `START_TIMEOUT`, it aborts on the N-th START cycle.
- **Reset mid-frame:** `tx_start` drops on the next edge. A byte the transmitter has already accepted completes on the line; that frame is not tracked.

## Configuration
- Macro: `UART_ARB_TAG_EN`.
- **Defined:** each grant sends 2 bytes.
  - Tag byte: {4'hA, 2'b00, grant_id}.
  - Payload byte follows; TAG states are used.
- **Undefined:** TAG states are not generated; each grant sends the payload only.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding.
  - Tag nibble constant 4'hA.
  - Default `START_TIMEOUT`.
- One sub-module: `bit_sync`, the SYNC_STAGES-deep single-bit synchronizer for `tx_busy`. It is reusable for the switch inputs.

## Test plan
- Reset, then `req[2]`=1 with data 0x5C, tag off:
  - `ack[2]` pulses once and `grant_id`=2.
  - `tx_data`=0x5C and `tx_start` stays high until busy is synced.
  - The line shows 0x5C.
- `req`=4'b1111 held with distinct bytes 0x10..0x13 → acks in order 0,1,2,3,0; each `ack` is a single cycle.
- Tag on, `req[1]`=0x07 → line shows 0xA1 then 0x07; `active` stays high through both bytes.
- `tx_busy` tied 0, `START_TIMEOUT`=16:
  - `err_timeout` pulses 16 cycles after `tx_start` rises.
  - FSM returns to IDLE and the next request is granted.
- `rst` pulsed during DATA_WAIT → all outputs return to reset values on the next edge; `req[0]` is then granted first.
- `req[3]` with N_REQ=2 → never acknowledged; `tx_start` stays 0.
